// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM encodings, requester ids and address-map defaults shared by the arbiter.
package mem_arbiter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;
  localparam int DATA_OFFSET_DEF = 32;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker; on contention the port not granted last wins.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic winner,
  output logic any
);
  always_comb begin
    any = if_req | d_req;
    winner = (if_req && d_req) ? ~last_grant : (d_req ? PORT_DATA : PORT_IF);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-port mem between a read-only fetch port and a read/write data port.
// Define MEM_ARB_BOUNDS_EN to reject data-port writes below DATA_OFFSET with d_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 7,
  parameter int DW          = 64,
  parameter int RD_LAT      = 1,
  parameter int DATA_OFFSET = DATA_OFFSET_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_mode,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] OFFS = AW'(DATA_OFFSET);
`ifdef MEM_ARB_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic win, last_grant, we, viol, pick, any, pick_we, bad;
  mem_arb_rr u_rr (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_grant(last_grant),
    .winner    (pick),
    .any       (any)
  );
  always_comb begin
    pick_we = (pick == PORT_DATA) && d_we;
    bad = BOUNDS && pick_we && (d_addr < OFFS);
    if_gnt = (state == ISSUE) && (win == PORT_IF);
    d_gnt = (state == ISSUE) && (win == PORT_DATA);
    d_err = (state == ISSUE) && viol;
    mem_mode = (state == ISSUE) && we && !viol;
    if_rvalid = (state == RESP) && (win == PORT_IF);
    d_rvalid = (state == RESP) && (win == PORT_DATA);
  end
  // mem_mode derives from state only, so the async reset kills any write immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      win <= PORT_DATA;
      last_grant <= PORT_DATA;
      we <= 1'b0;
      viol <= 1'b0;
      cnt <= '0;
      mem_addr <= '0;
      mem_data_in <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          win <= pick;
          we <= pick_we;
          viol <= bad;
          mem_addr <= (pick == PORT_DATA) ? d_addr : if_addr;
          if (pick_we) mem_data_in <= d_wdata;
          state <= ISSUE;
        end
        ISSUE: begin
          last_grant <= win;
          cnt <= CW'(RD_LAT - 1);
          state <= we ? IDLE : WAIT;
        end
        WAIT: if (cnt == '0) begin
          if (win == PORT_DATA) d_rdata <= mem_data_out;
          else if_rdata <= mem_data_out;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter against a synchronous-read mem model (RD_LAT=1).
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [6:0] if_addr = '0, d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_mode;
  logic [63:0] if_rdata, d_rdata, mem_data_in, mem_data_out;
  logic [6:0] mem_addr;
  logic [63:0] mem [128];
  int cyc = 0;
  int checks = 0, errors = 0;
  int last_if = -1;
  bit spacing = 1'b0;
  typedef struct {bit port; bit err; bit wr; int due;} gnt_t;
  typedef struct {bit port; logic [63:0] data; int due;} rd_t;
  gnt_t gq[$];
  rd_t rq[$];

  mem_arbiter #(.AW(7), .DW(64), .RD_LAT(1), .DATA_OFFSET(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_mode) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
  end

  function automatic logic [63:0] pre(int i);
    return (i < 32) ? 64'h1000 + 64'(i) : 64'hd000 + 64'(i);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    gnt_t g;
    rd_t r;
    if (!spacing) last_if = -1;
    if (reset) begin
      if (if_gnt || d_gnt) begin
        chk("gnt_both", 64'(if_gnt && d_gnt), 64'd0);
        if (gq.size() == 0) chk("gnt_unexpected", 64'd1, 64'd0);
        else begin
          g = gq.pop_front();
          chk("gnt_port", 64'(d_gnt), 64'(g.port));
          chk("gnt_err", 64'(d_err), 64'(g.err));
          chk("gnt_mode", 64'(mem_mode), 64'(g.wr && !g.err));
          if (g.due >= 0) chk("gnt_latency", 64'(cyc), 64'(g.due));
        end
      end
      if (mem_mode && !d_gnt) chk("spurious_mode", 64'd1, 64'd0);
      if (d_err && !d_gnt) chk("spurious_err", 64'd1, 64'd0);
      if (if_rvalid || d_rvalid) begin
        chk("rvalid_both", 64'(if_rvalid && d_rvalid), 64'd0);
        if (rq.size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
        else begin
          r = rq.pop_front();
          chk("rvalid_port", 64'(d_rvalid), 64'(r.port));
          chk("rdata", d_rvalid ? d_rdata : if_rdata, r.data);
          if (r.due >= 0) chk("rvalid_latency", 64'(cyc), 64'(r.due));
        end
      end
      if (if_rvalid && spacing) begin
        if (last_if >= 0) chk("fetch_spacing", 64'(cyc - last_if), 64'd4);
        last_if = cyc;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (rq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() > 0) chk("rvalid_timeout", 64'd1, 64'd0);
  endtask

  task automatic txn(bit port, bit we, logic [6:0] a, logic [63:0] wd, logic [63:0] rd, bit err, bit timed);
    int n = 0;
    gq.push_back('{port, err, we, timed ? cyc + 1 : -1});
    if (!we) rq.push_back('{port, rd, timed ? cyc + 3 : -1});
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? d_gnt : if_gnt) && n < 50);
    if (n >= 50) chk("gnt_timeout", 64'd1, 64'd0);
    if_req = 1'b0;
    d_req = 1'b0;
    if (!we) drain();
    @(negedge clk);
  endtask

  initial begin
    int n, ni, nd;
    for (int i = 0; i < 128; i++) mem[i] = pre(i);
    // T1: reset held with both requests pending
    if_req = 1'b1; d_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_reset_outputs", {58'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_mode, d_err}, 64'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    // T2: data write then read back
    txn(1'b1, 1'b1, 7'd32, 64'h00a5_5a01, 64'd0, 1'b0, 1'b1);
    txn(1'b1, 1'b0, 7'd32, 64'd0, 64'h00a5_5a01, 1'b0, 1'b1);
    // T3: continuous contention alternates IF, DATA, ...
    for (int i = 0; i < 4; i++) begin
      gq.push_back('{1'b0, 1'b0, 1'b0, -1});
      gq.push_back('{1'b1, 1'b0, 1'b0, -1});
      rq.push_back('{1'b0, pre(i), -1});
      rq.push_back('{1'b1, pre(33 + i), -1});
    end
    if_addr = 7'd0; d_addr = 7'd33; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    n = 0; ni = 0; nd = 0;
    while ((ni < 4 || nd < 4) && n < 200) begin
      @(negedge clk);
      n++;
      if (if_gnt) begin
        ni++;
        if (ni < 4) if_addr = 7'(ni); else if_req = 1'b0;
      end
      if (d_gnt) begin
        nd++;
        if (nd < 4) d_addr = 7'(33 + nd); else d_req = 1'b0;
      end
    end
    if (n >= 200) chk("t3_timeout", 64'd1, 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    drain();
    @(negedge clk);
    // T4: fetch stream with if_req held
    for (int i = 0; i < 8; i++) begin
      gq.push_back('{1'b0, 1'b0, 1'b0, -1});
      rq.push_back('{1'b0, pre(i), -1});
    end
    spacing = 1'b1;
    if_addr = 7'd0; if_req = 1'b1;
    n = 0; ni = 0;
    while (ni < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_gnt) begin
        ni++;
        if (ni < 8) if_addr = 7'(ni); else if_req = 1'b0;
      end
    end
    if (n >= 200) chk("t4_timeout", 64'd1, 64'd0);
    if_req = 1'b0;
    drain();
    spacing = 1'b0;
    @(negedge clk);
    // T5: writes into the instruction region
`ifdef MEM_ARB_BOUNDS_EN
    txn(1'b1, 1'b1, 7'd5, 64'hbad0_0005, 64'd0, 1'b1, 1'b1);
    txn(1'b1, 1'b0, 7'd5, 64'd0, 64'h1005, 1'b0, 1'b1);
    txn(1'b1, 1'b1, 7'd31, 64'hbad0_001f, 64'd0, 1'b1, 1'b1);
    txn(1'b1, 1'b0, 7'd31, 64'd0, 64'h101f, 1'b0, 1'b1);
`else
    txn(1'b1, 1'b1, 7'd5, 64'hbad0_0005, 64'd0, 1'b0, 1'b1);
    txn(1'b1, 1'b0, 7'd5, 64'd0, 64'hbad0_0005, 1'b0, 1'b1);
    txn(1'b1, 1'b1, 7'd31, 64'hbad0_001f, 64'd0, 1'b0, 1'b1);
    txn(1'b1, 1'b0, 7'd31, 64'd0, 64'hbad0_001f, 1'b0, 1'b1);
`endif
    // T6: reset during WAIT drops the read
    gq.push_back('{1'b1, 1'b0, 1'b0, -1});
    d_we = 1'b0; d_addr = 7'd32; d_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_gnt && n < 50);
    if (n >= 50) chk("t6_gnt_timeout", 64'd1, 64'd0);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_rvalid", {62'd0, d_rvalid, mem_mode}, 64'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_after_reset", {62'd0, d_rvalid, if_rvalid}, 64'd0);
    end
    txn(1'b1, 1'b0, 7'd32, 64'd0, 64'h00a5_5a01, 1'b0, 1'b1);
    chk("gnt_queue_empty", 64'(gq.size()), 64'd0);
    chk("rd_queue_empty", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
